// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, FSM states and opcode helper shared by the ALU.
package alu_pkg;
  localparam logic [3:0] OP_ADDU  = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUBU  = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_NAND  = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_MULTU = 4'b0110;
  localparam logic [3:0] OP_SLL   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_SLT   = 4'b1010;
  localparam logic [3:0] OP_SLTU  = 4'b1011;
  typedef enum logic {IDLE, MUL} state_t;
  function automatic logic is_legal(input logic [3:0] op);
    return op < 4'b1100;
  endfunction
endpackage

// File: rtl/mul_shift_add.sv
// mul_shift_add: unsigned shift-add multiplier, one multiplier bit per cycle over WIDTH cycles.
module mul_shift_add #(parameter int WIDTH = 32) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int SHW = $clog2(WIDTH);
  logic [WIDTH-1:0] mcand, acc, mplier;
  logic [SHW-1:0] count;
  logic [WIDTH:0] sum;
  assign sum = {1'b0, acc} + {1'b0, mplier[0] ? mcand : {WIDTH{1'b0}}};
  // product is the post-step value so the final step can be captured on the same edge
  assign product = {sum, mplier[WIDTH-1:1]};
  assign done = busy && count == SHW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      count <= '0;
      busy <= 1'b0;
    end else if (start) begin
      mcand <= a;
      mplier <= b;
      acc <= '0;
      count <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc <= sum[WIDTH:1];
      mplier <= {sum[0], mplier[WIDTH-1:1]};
      count <= count + 1'b1;
      busy <= !done;
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle integer ops and a WIDTH-cycle multu into HI/LO.
module alu_seq import alu_pkg::*; #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int SHW = $clog2(WIDTH);
  state_t state;
  logic accept, is_sub, ovf, mul_busy, mul_done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0] sum;
  logic [SHW-1:0] sh;
  logic [WIDTH-1:0] r;
  assign in_ready = state == IDLE && !mul_busy && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign is_sub = op == OP_SUBU || op == OP_SUB;
  assign sum = {1'b0, a} + {1'b0, is_sub ? ~b : b} + {{WIDTH{1'b0}}, is_sub};
  assign sh = b[SHW-1:0];
  assign ovf = op == OP_ADD ? a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1] :
               op == OP_SUB ? a[WIDTH-1] != b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1] : 1'b0;
  always_comb begin
    r = '0;
    case (op)
      OP_ADDU, OP_ADD, OP_SUBU, OP_SUB: r = sum[WIDTH-1:0];
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $unsigned($signed(a) >>> sh);
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, a < b};
      default: r = '0;
    endcase
  end
  mul_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .rst_n(rst_n), .start(accept && op == OP_MULTU), .a(a), .b(b),
    .busy(mul_busy), .done(mul_done), .product(product)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      out_valid <= 1'b0;
      result <= '0;
      cout <= 1'b0;
      overflow <= 1'b0;
      illegal <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else if (state == MUL) begin
      if (mul_done) begin
        state <= IDLE;
        out_valid <= 1'b1;
        {hi, lo} <= product;
        result <= product[WIDTH-1:0];
        cout <= 1'b0;
        overflow <= 1'b0;
        illegal <= 1'b0;
      end
    end else if (accept) begin
      state <= op == OP_MULTU ? MUL : IDLE;
      out_valid <= op != OP_MULTU;
      if (op != OP_MULTU) begin
        result <= r;
        cout <= op <= OP_SUB ? sum[WIDTH] : 1'b0;
        overflow <= ovf;
        illegal <= !is_legal(op);
      end
    end else if (out_ready)
      out_valid <= 1'b0;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq against a transaction-level model.
module tb_alu_seq;
  import alu_pkg::*;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [3:0] op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, cout, overflow, illegal;
  logic [W-1:0] result, hi, lo;
  int total = 0, bad = 0;
  logic m_valid, m_cout, m_ovf, m_ill;
  logic [W-1:0] m_result, m_hi, m_lo;
  logic [2*W-1:0] m_prod;
  int m_left;
  logic [W-1:0] corner [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
  always #5 clk = ~clk;
  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .cout(cout),
    .overflow(overflow), .illegal(illegal), .hi(hi), .lo(lo)
  );
  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
    end
  endtask
  task automatic ref_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] r, output logic c, output logic v, output logic il);
    longint sx, sy, lim, s;
    longint unsigned ux, uy;
    int sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = x;
    uy = y;
    lim = longint'(1) <<< (W - 1);
    sh = int'(y % W);
    r = '0;
    c = 0;
    v = 0;
    il = 0;
    case (o)
      OP_ADDU, OP_ADD: begin
        r = W'(ux + uy);
        c = ((ux + uy) >> W) != 0;
        s = sx + sy;
        v = o == OP_ADD && (s > lim - 1 || s < -lim);
      end
      OP_SUBU, OP_SUB: begin
        r = W'(ux - uy);
        c = ux >= uy;
        s = sx - sy;
        v = o == OP_SUB && (s > lim - 1 || s < -lim);
      end
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      OP_SLL:  r = x << sh;
      OP_SRL:  r = x >> sh;
      OP_SRA:  r = W'(sx >>> sh);
      OP_SLT:  r = W'(sx < sy);
      OP_SLTU: r = W'(ux < uy);
      default: il = 1;
    endcase
  endtask
  task automatic model_reset();
    m_valid = 0; m_cout = 0; m_ovf = 0; m_ill = 0;
    m_result = '0; m_hi = '0; m_lo = '0; m_prod = '0; m_left = 0;
  endtask
  // advances the model by one clock edge, using the inputs that were present at that edge
  task automatic model_step();
    logic rdy, c, v, il;
    logic [W-1:0] r;
    rdy = m_left == 0 && (!m_valid || out_ready);
    if (m_valid && out_ready) m_valid = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = m_prod[2*W-1:W]; m_lo = m_prod[W-1:0]; m_result = m_lo;
        m_cout = 0; m_ovf = 0; m_ill = 0; m_valid = 1;
      end
    end else if (in_valid && rdy) begin
      if (op == OP_MULTU) begin
        m_prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        m_left = W;
      end else begin
        ref_op(op, a, b, r, c, v, il);
        m_result = r; m_cout = c; m_ovf = v; m_ill = il; m_valid = 1;
      end
    end
  endtask
  task automatic cycle(input logic iv, input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic ordy);
    in_valid = iv; op = o; a = x; b = y; out_ready = ordy;
    @(posedge clk);
    #2 model_step();
  endtask
  task automatic do_reset();
    rst_n = 0;
    model_reset();
    in_valid = 0;
    out_ready = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
  endtask
  always @(negedge clk) if (rst_n) begin
    chk("in_ready", W'(in_ready), W'(m_left == 0 && (!m_valid || out_ready)));
    chk("out_valid", W'(out_valid), W'(m_valid));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    if (m_valid) begin
      chk("result", result, m_result);
      chk("cout", W'(cout), W'(m_cout));
      chk("overflow", W'(overflow), W'(m_ovf));
      chk("illegal", W'(illegal), W'(m_ill));
    end
  end
  initial begin
    do_reset();
    chk("rst_valid", W'(out_valid), 0);
    chk("rst_result", result, 0);
    chk("rst_hi", hi, 0);
    chk("rst_ready", W'(in_ready), 1);
    cycle(1, OP_ADD, 32'h7FFFFFFF, 32'h1, 1);
    chk("add_valid", W'(out_valid), 1);
    chk("add_r", result, 32'h80000000);
    chk("add_ovf", W'(overflow), 1);
    chk("add_cout", W'(cout), 0);
    cycle(1, OP_SUB, 32'h80000000, 32'h1, 1);
    chk("sub_r", result, 32'h7FFFFFFF);
    chk("sub_ovf", W'(overflow), 1);
    chk("sub_cout", W'(cout), 1);
    cycle(1, OP_SUBU, 32'h0, 32'h1, 1);
    chk("subu_r", result, 32'hFFFFFFFF);
    chk("subu_cout", W'(cout), 0);
    chk("subu_ovf", W'(overflow), 0);
    cycle(1, OP_SRA, 32'h80000000, 32'h24, 1);
    chk("sra_r", result, 32'hF8000000);
    cycle(1, OP_SRL, 32'h80000000, 32'h24, 1);
    chk("srl_r", result, 32'h08000000);
    cycle(1, OP_SLT, 32'hFFFFFFFF, 32'h1, 1);
    chk("slt_r", result, 1);
    cycle(1, OP_SLTU, 32'hFFFFFFFF, 32'h1, 1);
    chk("sltu_r", result, 0);
    cycle(1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    for (int i = 1; i <= W; i++) begin
      chk("mul_busy_ready", W'(in_ready), 0);
      cycle(1, OP_ADDU, $urandom, $urandom, 1);
    end
    chk("mul_valid", W'(out_valid), 1);
    chk("mul_hi", hi, 32'hFFFFFFFE);
    chk("mul_lo", lo, 32'h00000001);
    chk("mul_r", result, 32'h00000001);
    cycle(0, OP_ADDU, 0, 0, 1);
    cycle(1, OP_ADDU, 5, 6, 0);
    chk("stall_first", result, 11);
    repeat (3) begin
      cycle(1, OP_ADDU, 7, 8, 0);
      chk("stall_r", result, 11);
      chk("stall_ready", W'(in_ready), 0);
    end
    cycle(1, OP_ADDU, 7, 8, 1);
    chk("drain_accept_r", result, 15);
    chk("drain_accept_valid", W'(out_valid), 1);
    cycle(0, OP_ADDU, 0, 0, 1);
    chk("drain_empty", W'(out_valid), 0);
    cycle(1, 4'hE, 1, 2, 1);
    chk("ill_flag", W'(illegal), 1);
    chk("ill_r", result, 0);
    chk("ill_hi", hi, 32'hFFFFFFFE);
    chk("ill_lo", lo, 32'h1);
    cycle(1, OP_MULTU, 3, 5, 1);
    repeat (9) cycle(0, OP_ADDU, 0, 0, 1);
    rst_n = 0;
    model_reset();
    #1;
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_valid", W'(out_valid), 0);
    in_valid = 0;
    @(posedge clk);
    #2 rst_n = 1;
    #1 chk("abort_ready", W'(in_ready), 1);
    repeat (40) cycle(0, OP_ADDU, 0, 0, 1);
    chk("abort_lo_after", lo, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] x, y;
      x = $urandom_range(0, 3) == 0 ? corner[$urandom_range(0, 4)] : $urandom;
      y = $urandom_range(0, 3) == 0 ? corner[$urandom_range(0, 4)] : $urandom;
      cycle($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), x, y, $urandom_range(0, 9) < 7);
    end
    repeat (40) cycle(0, OP_ADDU, 0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked, multi-cycle successor to the combinational integer ALU. It executes add/sub with overflow and carry, logic ops, true logical and arithmetic shifts, and set-less-than in one registered cycle. It executes an unsigned iterative shift-add multiply into persistent HI/LO registers in WIDTH cycles. It sits between the decode/issue stage and writeback, with valid/ready flow control on both sides.

Parameters:
WIDTH, 32, operand/result width in bits; must be a power of two and at least 8.
SHW, $clog2(WIDTH), shift-amount width (derived localparam, not overridable).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operands and opcode valid.
in_ready  out  1  block accepts a new operation this cycle.
op  in  4  opcode (see Behaviour).
a  in  WIDTH  operand A.
b  in  WIDTH  operand B; shifts use b[SHW-1:0].
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
result  out  WIDTH  primary result.
cout  out  1  adder carry-out; for sub, 1 = no borrow.
overflow  out  1  signed overflow (op 0001/0011 only, else 0).
illegal  out  1  opcode undefined.
hi  out  WIDTH  upper product register.
lo  out  WIDTH  lower product register.

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low. On reset: state=IDLE; out_valid, result, cout, overflow, illegal, hi, lo, and the multiplier counter all 0.
- Opcodes: 0000 addu, 0001 add, 0010 subu, 0011 sub, 0100 nand, 0101 nor, 0110 multu, 0111 sll, 1000 srl, 1001 sra, 1010 slt (signed, result 0/1), 1011 sltu. 1100-1111 are illegal.
- Accept occurs when in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Single-cycle ops: on accept, result/flags are registered. out_valid rises the next cycle (latency 1).
- Sub is a + ~b + 1 on a WIDTH+1-bit adder; cout is bit WIDTH.
- add overflow = (a[W-1]==b[W-1]) && (r[W-1]!=a[W-1]).
- sub overflow = (a[W-1]!=b[W-1]) && (r[W-1]!=a[W-1]).
- cout is meaningful only for add/sub ops, else 0.
- Shift amounts of WIDTH-1 or less come from b[SHW-1:0]; upper bits of b are ignored. sra replicates a[W-1].
- multu: IDLE->MUL on accept. Operands are latched, the accumulator is cleared, and count=0.
- In MUL, each cycle processes one multiplier bit (add multiplicand if LSB set, shift right). Count increments each cycle.
- After WIDTH cycles, hi/lo are written, result=lo, out_valid=1, and the state returns to IDLE. Latency is WIDTH+1 cycles from accept to out_valid.
- hi/lo change only on multu completion and hold otherwise.
- Illegal opcode: result=0, illegal=1, out_valid next cycle, hi/lo unchanged.
- Output hold: while out_valid && !out_ready, result and all flags are stable and no new op is accepted.
- Simultaneous drain and accept: out_valid stays 1 with new data.
- Only one operation is in flight at a time; in_ready=0 throughout MUL.
- Reset asserted mid-MUL aborts the multiply. hi/lo return to 0 and no out_valid is produced.
- Inputs a, b, and op are sampled only at accept; changes during MUL have no effect.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_ADDU ... OP_SLTU);
  - state encoding (IDLE, MUL);
  - function is_legal(op).
- One sub-module is natural: mul_shift_add (WIDTH param; start, a, b in; busy, done, product[2*WIDTH-1:0] out). It owns the counter and accumulator.
- alu_seq owns the handshake, single-cycle datapath, and HI/LO.

Test Plan:
- add 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow=1, cout=0, out_valid one cycle after accept.
- sub 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, overflow=1, cout=1. subu 0x0 - 0x1 -> 0xFFFFFFFF, cout=0, overflow=0.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, result=0x00000001. in_ready=0 for cycles 1-32. Change a/b mid-op -> same product.
- sra 0x80000000 by b=0x24 (uses 4) -> 0xF8000000. srl same -> 0x08000000. slt 0xFFFFFFFF,0x1 -> 1; sltu same -> 0.
- Back-to-back addu with out_ready held 0 for 3 cycles -> result stable, in_ready=0. Release -> second op accepted on the drain cycle, no lost or duplicated result.
- Assert rst_n=0 at MUL cycle 10, release -> out_valid never rises, hi=lo=0, in_ready=1 next cycle. Opcode 1110 -> illegal=1, result=0.
